// File: rtl/oam_dma_engine.sv
// oam_dma_engine: OAM DMA controller.
// Copies NBYTES bytes from a CPU-selected 256-byte page into OAM. An FF46
// write latches the source page, waits SETUP_CYCLES clocks, then spends
// CYC_PER_BYTE clocks on each byte slot. The OAM write happens in the last
// cycle of each slot. Source pages $E0-$FF are remapped to the WRAM echo.
//
// Optional build macro: OAM_DMA_DONE_IRQ_EN. When it is defined, done pulses
// for one cycle after the final OAM write of a completed copy. When it is
// undefined, done is tied low.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   reg_wr, reg_wdata    CPU write to FF46 (already decoded) and its data
//   reg_rdata            current FF46 value
//   busy                 transfer in progress (SETUP or XFER)
//   src_addr, src_rd     source read address and request (held per slot)
//   src_vram             source address lies in $8000-$9FFF
//   src_data             source read data
//   oam_addr, oam_wdata  OAM write index and data
//   oam_we               OAM write enable
//   done                 completion pulse (see macro above)
module oam_dma_engine #(
  parameter int unsigned SETUP_CYCLES = 4,
  parameter int unsigned CYC_PER_BYTE = 4,
  parameter int unsigned NBYTES       = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        busy,
  output logic [15:0] src_addr,
  output logic        src_rd,
  output logic        src_vram,
  input  logic [7:0]  src_data,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  output logic        done
);

  localparam int SCW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam int PW  = $clog2(CYC_PER_BYTE);

  typedef enum logic [1:0] {IDLE, SETUP, XFER} state_t;

  state_t          state_q, state_d;
  logic [7:0]      base_q;
  logic [SCW-1:0]  setup_q, setup_d;
  logic [7:0]      idx_q, idx_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [7:0]      ep;
  logic            slot_end;
  logic            last_wr;

  // Pages $E0-$FF read the WRAM echo, i.e. 32 pages lower.
  assign ep        = (base_q >= 8'hE0) ? (base_q - 8'h20) : base_q;
  assign reg_rdata = base_q;
  assign slot_end  = (phase_q == PW'(CYC_PER_BYTE - 1));
  // Final OAM write of a copy happens in this cycle.
  assign last_wr   = (state_q == XFER) && slot_end && (idx_q == 8'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      setup_q <= '0;
      idx_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      setup_q <= setup_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      if (reg_wr) base_q <= reg_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    setup_d   = setup_q;
    idx_d     = idx_q;
    phase_d   = phase_q;
    busy      = 1'b0;
    src_rd    = 1'b0;
    src_addr  = '0;
    src_vram  = 1'b0;
    oam_we    = 1'b0;
    oam_addr  = '0;
    oam_wdata = 8'hFF;

    case (state_q)
      IDLE: ;
      SETUP: begin
        busy = 1'b1;
        if (setup_q == SCW'(SETUP_CYCLES - 1)) begin
          state_d = XFER;
          setup_d = '0;
          idx_d   = '0;
          phase_d = '0;
        end else begin
          setup_d = setup_q + SCW'(1);
        end
      end
      XFER: begin
        busy     = 1'b1;
        src_rd   = 1'b1;
        src_addr = {ep, 8'h00} + {8'h00, idx_q};
        src_vram = (src_addr[15:13] == 3'b100);
        phase_d  = phase_q + PW'(1);
        if (slot_end) begin
          oam_we    = 1'b1;
          oam_addr  = idx_q;
          oam_wdata = src_data;
          phase_d   = '0;
          if (last_wr) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A register write overrides everything and restarts from SETUP; the
    // current cycle's OAM write (if any) is still issued above.
    if (reg_wr) begin
      state_d = SETUP;
      setup_d = '0;
      idx_d   = '0;
      phase_d = '0;
    end
  end

`ifdef OAM_DMA_DONE_IRQ_EN
  logic done_q;
  always_ff @(posedge clk) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= last_wr && !reg_wr;
  end
  assign done = done_q;
`else
  assign done = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma_engine.sv
module tb_oam_dma_engine;

  localparam int S     = 4;
  localparam int C     = 4;
  localparam int N     = 160;
  localparam int XEND  = S + N * C;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        busy;
  logic [15:0] src_addr;
  logic        src_rd;
  logic        src_vram;
  logic [7:0]  src_data;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        done;

  logic [7:0]  mem     [0:65535];
  logic [7:0]  oam_mem [0:255];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit  active = 0;
  int  n      = 0;
  int  base_m = 0;
  int  rdata_e = 0;

  oam_dma_engine #(.SETUP_CYCLES(S), .CYC_PER_BYTE(C), .NBYTES(N)) dut (
    .clk(clk), .rst(rst), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .busy(busy), .src_addr(src_addr), .src_rd(src_rd),
    .src_vram(src_vram), .src_data(src_data), .oam_addr(oam_addr),
    .oam_wdata(oam_wdata), .oam_we(oam_we), .done(done)
  );

  always #5 clk = ~clk;

  assign src_data = mem[src_addr];

  // OAM RAM model written by the DUT's write port
  always @(posedge clk) if (oam_we) oam_mem[oam_addr] <= oam_wdata;

  function automatic int eff(input int page);
    return (page >= 224) ? page - 32 : page;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit wr, input bit rs, input logic [7:0] d);
    bit busy_e, rd_e, we_e, vram_e, done_e;
    int k, addr_e;
    @(negedge clk);
    rst = rs; reg_wr = wr; reg_wdata = d;
    @(posedge clk);
    #1;
    if (rs) begin active = 0; n = 0; rdata_e = 0; end
    else if (wr) begin active = 1; n = 1; base_m = int'(d); rdata_e = int'(d); end
    else if (active) n++;
    busy_e = 0; rd_e = 0; we_e = 0; done_e = 0; k = 0; addr_e = 0;
    if (active) begin
      busy_e = (n <= XEND);
      if (n > S && n <= XEND) begin
        rd_e   = 1;
        k      = (n - S - 1) / C;
        addr_e = eff(base_m) * 256 + k;
        we_e   = ((n - S) % C) == 0;
      end
      if (n == XEND + 1) begin done_e = 1; active = 0; end
    end
`ifndef OAM_DMA_DONE_IRQ_EN
    done_e = 0;
`endif
    vram_e = rd_e && addr_e >= 32'h8000 && addr_e < 32'hA000;
    chk("busy", busy, busy_e);
    chk("src_rd", src_rd, rd_e);
    chk("src_vram", src_vram, vram_e);
    chk("oam_we", oam_we, we_e);
    chk("reg_rdata", reg_rdata, rdata_e);
    chk("done", done, done_e);
    if (rd_e || !busy_e) chk("src_addr", src_addr, addr_e);
    if (we_e) begin
      chk("oam_addr", oam_addr, k);
      chk("oam_wdata", oam_wdata, mem[addr_e]);
    end
    if (rs) begin
      chk("rst_oam_wdata", oam_wdata, 8'hFF);
      chk("rst_oam_addr", oam_addr, 8'h00);
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) step(1'b0, 1'b0, 8'h00);
  endtask

  // OAM bytes below lo_cnt come from page ep_lo, the rest from page ep_hi.
  task automatic check_oam(input string tag, input int ep_lo, input int lo_cnt, input int ep_hi);
    for (int i = 0; i < N; i++)
      chk(tag, oam_mem[i], (i < lo_cnt) ? mem[ep_lo * 256 + i] : mem[ep_hi * 256 + i]);
  endtask

  initial begin
    int pg;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    rst = 1'b1; reg_wr = 1'b0; reg_wdata = 8'h00;

    repeat (3) step(1'b0, 1'b1, 8'h00);

    // Basic copy from WRAM page C1
    step(1'b1, 1'b0, 8'hC1); run(650);
    check_oam("oam_c1", eff(8'hC1), N, eff(8'hC1));

    // VRAM source
    step(1'b1, 1'b0, 8'h80); run(650);
    check_oam("oam_80", eff(8'h80), N, eff(8'h80));

    // Echo remap
    step(1'b1, 1'b0, 8'hE3); run(650);
    check_oam("oam_e3", eff(8'hE3), N, eff(8'hE3));

    // Restart during byte 50
    step(1'b1, 1'b0, 8'hC0); run(S + 50 * C);
    step(1'b1, 1'b0, 8'hD0); run(650);
    check_oam("oam_d0", eff(8'hD0), N, eff(8'hD0));

    // Reset during byte 100: bytes 0..99 from page 10, rest still from D0
    step(1'b1, 1'b0, 8'h10); run(S + 100 * C);
    step(1'b0, 1'b1, 8'h00); run(5);
    check_oam("oam_rst", eff(8'h10), 100, eff(8'hD0));

    // Write coinciding with the final-byte cycle
    step(1'b1, 1'b0, 8'h45); run(XEND - 1);
    step(1'b1, 1'b0, 8'h46); run(650);
    check_oam("oam_46", eff(8'h46), N, eff(8'h46));

    // Random pages
    for (int r = 0; r < 2; r++) begin
      pg = int'($urandom_range(0, 255));
      step(1'b1, 1'b0, 8'(pg)); run(650);
      check_oam("oam_rand", eff(pg), N, eff(pg));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_engine.md
Name: oam_dma_engine

Overview:
- Standalone OAM DMA controller. It sequences the 160-byte copy from a CPU-selected 256-byte page into OAM ($FE00-$FE9F).
- It owns the FF46 register and drives the source-side bus request: cartridge/WRAM bus or VRAM.
- It drives the OAM write port and a busy flag. The MMU uses busy to restrict the CPU to HRAM and to mask interrupts.
- Sits beside the MMU address mux, between the CPU MMIO decode and the OAM RAM.

Parameters:
- SETUP_CYCLES, 4: clk cycles from an FF46 write to the first transfer slot.
- CYC_PER_BYTE, 4: clk cycles per byte slot (one machine cycle). Must be a power of 2, ≥2.
- NBYTES, 160: bytes copied per transfer.

Ports:
- clk, in, 1: system clock (XTAL rate).
- rst, in, 1: reset.
- reg_wr, in, 1: CPU write strobe, already decoded for address $FF46.
- reg_wdata, in, 8: CPU write data (source page).
- reg_rdata, out, 8: current FF46 value, readable at any time.
- busy, out, 1: high from the cycle after reg_wr until the cycle after the last OAM write.
- src_addr, out, 16: source byte address.
- src_rd, out, 1: source read request, held for the whole slot.
- src_vram, out, 1: high when src_addr is in $8000-$9FFF (MMU routes the request to the VRAM bus, otherwise to the cart/WRAM bus).
- src_data, in, 8: source read data from the selected bus.
- oam_addr, out, 8: OAM write index 0..NBYTES-1.
- oam_wdata, out, 8: OAM write data.
- oam_we, out, 1: OAM write enable.
- done, out, 1: completion pulse (see Optional Feature).

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk.
  - Reset values: reg_rdata=8'h00, busy=0, src_rd=0, src_vram=0, src_addr=0, oam_we=0, oam_addr=0, oam_wdata=8'hFF, done=0. State is IDLE.
  - Reset mid-transfer aborts immediately. OAM keeps the bytes already written.
- States: IDLE, SETUP, XFER.
- FF46 write (reg_wr=1) in any state:
  - latch base=reg_wdata and set reg_rdata=reg_wdata next cycle;
  - clear the setup counter, byte index and phase;
  - enter SETUP.
  - A write during XFER aborts the current copy with no gap: busy stays 1 and no further oam_we until the new XFER begins.
  - A write during SETUP restarts the SETUP count.
- SETUP:
  - busy=1, src_rd=0, oam_we=0.
  - After SETUP_CYCLES cycles in SETUP, enter XFER with idx=0, phase=0.
- XFER:
  - Effective page ep = base≥8'hE0 ? base-8'h20 : base, so $E0-$FF pages read the WRAM echo.
  - src_addr={ep,8'h00}+idx. src_rd=1.
  - src_vram=(src_addr[15:13]==3'b100).
  - phase counts 0..CYC_PER_BYTE-1.
  - On phase==CYC_PER_BYTE-1: oam_we=1 for that single cycle, oam_addr=idx, oam_wdata=src_data sampled combinationally in that cycle.
  - Then idx increments and phase wraps to 0.
  - After the write with idx==NBYTES-1: next state IDLE, busy=0, src_rd=0.
  - Total XFER length is NBYTES*CYC_PER_BYTE cycles (640 with defaults). Latency from the reg_wr edge to the first oam_we is SETUP_CYCLES+CYC_PER_BYTE cycles.
- IDLE: busy=0, src_rd=0, oam_we=0, src_addr=0.
- idx is 8 bits. The addition {ep,8'h00}+idx never carries beyond the page, since idx<256.
- reg_wr in the same cycle as the final write: the final write still occurs, then the block goes to SETUP (not IDLE), and busy stays 1.

Optional Feature:
- Macro: OAM_DMA_DONE_IRQ_EN.
- Defined: done pulses 1 for exactly one cycle, the cycle after the final OAM write completes, as the block enters IDLE.
  - No pulse for aborted (restarted) or reset transfers.
- Undefined: done is tied to 0 and no completion logic is built.

Test Plan:
- Reset, then write 8'hC1 → after 4 cycles, busy=1 and src_addr=$C100, src_rd=1. The first oam_we fires at cycle 8 with oam_addr=0. The last oam_we is at oam_addr=159 from src_addr $C19F. busy falls 640 cycles after XFER entry, and reg_rdata=8'hC1 throughout.
- Write 8'h80 → src_vram=1 for all slots, src_addr $8000-$809F. Bench VRAM model data appears in OAM 0..159 in order.
- Write 8'hE3 → src_addr runs $C300-$C39F (echo remap), and reg_rdata reads back 8'hE3.
- Write 8'hC0, then write 8'hD0 at byte 50 of XFER → no oam_we for 4+4 cycles, then the copy restarts at oam_addr=0 from $D000. busy never drops. With OAM_DMA_DONE_IRQ_EN, exactly one done pulse occurs, at the end of the D0 copy.
- Assert rst at byte 100 → next cycle busy=0, oam_we=0, reg_rdata=0. OAM bytes 0..99 retain the copied values.
- Write during the final-byte cycle → byte 159 is written, busy stays 1, and the new SETUP begins with no done pulse.
